instr_fetch_unit: RTL

- Front-end stage of the 8-bit-address / 16-bit-instruction CPU.
- Owns the program counter, issues reads to the synchronous instruction/data RAM, and captures the returned word into the instruction register.
- The decoder consumes that register; the controller sequences it through a request/valid handshake.
- Replaces the loose PC/IR muxing at top level with a self-contained FSM that tolerates multi-cycle RAM read latency and handles branch loads that arrive mid-fetch.

---
 rtl/instr_fetch_unit_if.sv | 31 +++
 rtl/instr_fetch_unit.sv | 138 +++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - control, RAM read and decoder-side signals of the fetch unit
interface instr_fetch_unit_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
);
  logic               start;
  logic [ADDR_W-1:0]  start_pc;
  logic               fetch_req;
  logic               pc_load;
  logic [ADDR_W-1:0]  pc_target;
  logic [INSTR_W-1:0] ram_r_data;
  logic [ADDR_W-1:0]  ram_r_addr;
  logic               ram_rd_en;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic [ADDR_W-1:0]  pc;
  logic               instr_valid;
  logic               busy;
  logic               halted;

  // master: the fetch unit itself, which masters the RAM read port
  modport master (
    input  start, start_pc, fetch_req, pc_load, pc_target, ram_r_data,
    output ram_r_addr, ram_rd_en, instr, instr_pc, pc, instr_valid, busy, halted
  );

  modport slave (
    output start, start_pc, fetch_req, pc_load, pc_target, ram_r_data,
    input  ram_r_addr, ram_rd_en, instr, instr_pc, pc, instr_valid, busy, halted
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC/IR fetch FSM with multi-cycle RAM read and deferred branch load
// Optional HALT-word detection is enabled by defining FETCH_HALT_DETECT_EN.
module instr_fetch_unit #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16,
  parameter int RD_LAT  = 1
) (
  input logic                clk,
  input logic                rst_n,
  instr_fetch_unit_if.master bus
);
`ifdef FETCH_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif
  localparam logic [INSTR_W-1:0] HALT_WORD = INSTR_W'(16'hE000);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, HOLD} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0]  pend_target_q, pend_target_d;
  logic               halted_q, halted_d;
  logic [1:0]         cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      addr_q        <= '0;
      instr_pc_q    <= '0;
      instr_q       <= '0;
      valid_q       <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      halted_q      <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      addr_q        <= addr_d;
      instr_pc_q    <= instr_pc_d;
      instr_q       <= instr_d;
      valid_q       <= valid_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      halted_q      <= halted_d;
      cnt_q         <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    addr_d        = addr_q;
    instr_pc_d    = instr_pc_q;
    instr_d       = instr_q;
    valid_d       = valid_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    halted_d      = halted_q;
    cnt_d         = cnt_q;

    if (bus.start) begin
      pc_d         = bus.start_pc;
      valid_d      = 1'b0;
      pend_valid_d = 1'b0;
      halted_d     = 1'b0;
      state_d      = FETCH;
    end else begin
      case (state_q)
        IDLE: ;
        FETCH: begin
          addr_d  = pc_q;
          cnt_d   = 2'(RD_LAT - 1);
          state_d = WAIT;
          if (bus.pc_load) begin
            pend_target_d = bus.pc_target;
            pend_valid_d  = 1'b1;
          end
        end
        WAIT: begin
          if (bus.pc_load) begin
            pend_target_d = bus.pc_target;
            pend_valid_d  = 1'b1;
          end
          if (cnt_q == 2'd0) begin
            instr_d    = bus.ram_r_data;
            instr_pc_d = pc_q;
            valid_d    = 1'b1;
            state_d    = HOLD;
            // A branch arriving on the capture edge itself is the newest target
            if (bus.pc_load) begin
              pc_d         = bus.pc_target;
              pend_valid_d = 1'b0;
            end else if (pend_valid_q) begin
              pc_d         = pend_target_q;
              pend_valid_d = 1'b0;
            end else begin
              pc_d = pc_q + ADDR_W'(1);
            end
            if (HALT_EN && bus.ram_r_data == HALT_WORD) begin
              halted_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
        HOLD: begin
          if (bus.pc_load) begin
            pc_d = bus.pc_target;
          end
          if (bus.fetch_req && !halted_q) begin
            valid_d = 1'b0;
            state_d = FETCH;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // The address is presented combinationally in FETCH and held through WAIT
  assign bus.ram_r_addr  = (state_q == FETCH) ? pc_q : addr_q;
  assign bus.ram_rd_en   = (state_q == FETCH);
  assign bus.busy        = (state_q == FETCH) || (state_q == WAIT);
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.pc          = pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.halted      = halted_q;
endmodule
